// File: rtl/lb_burst_arbiter_if.sv
// Request-side and local-bus signals of the two-port burst arbiter.
// The arbiter connects through the slave modport; requesters and the bus model use master.
interface lb_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
);
  logic [1:0]              req;
  logic [1:0]              req_wr;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*LEN_WIDTH-1:0]  req_len;
  logic [1:0]              gnt;
  logic [1:0]              wready;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic [1:0]              rvalid_o;
  logic                    rlast_o;
  logic                    err;
  logic                    busy;
  logic                    lb_wren;
  logic                    lb_rden;
  logic                    lb_rdenlast;
  logic [ADDR_WIDTH-1:0]   lb_waddr;
  logic [ADDR_WIDTH-1:0]   lb_raddr;
  logic [DATA_WIDTH-1:0]   lb_wdata;
  logic [DATA_WIDTH-1:0]   lb_rdata;
  logic                    lb_rvalid;
  logic                    lb_rvalidlast;

  modport slave (
    input  req, req_wr, req_addr, req_len, wdata, lb_rdata, lb_rvalid, lb_rvalidlast,
    output gnt, wready, rdata_o, rvalid_o, rlast_o, err, busy,
           lb_wren, lb_rden, lb_rdenlast, lb_waddr, lb_raddr, lb_wdata
  );

  modport master (
    output req, req_wr, req_addr, req_len, wdata, lb_rdata, lb_rvalid, lb_rvalidlast,
    input  gnt, wready, rdata_o, rvalid_o, rlast_o, err, busy,
           lb_wren, lb_rden, lb_rdenlast, lb_waddr, lb_raddr, lb_wdata
  );
endinterface

// File: rtl/lb_burst_arbiter.sv
// Two-port round-robin burst arbiter and sequencer in front of the local-bus BRAM controller.
// Grants one contiguous write or read burst at a time and steers read returns to the owner.
module lb_burst_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rstn,
  lb_burst_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state, state_d;
  logic                  owner, owner_d;
  logic                  prio, prio_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [LEN_WIDTH-1:0]  remain, remain_d;
  logic [TW-1:0]         tcnt, tcnt_d;

  logic [1:0]            gnt_q, gnt_d;
  logic                  err_q, err_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  rdenlast_q, rdenlast_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  winner;
  logic                  win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_len;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  reading;

  // With both ports requesting, prio decides; otherwise the single requester wins.
  assign winner    = (bus.req == 2'b11) ? prio : bus.req[1];
  assign win_wr    = bus.req_wr[winner];
  assign win_addr  = winner ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
  assign win_len   = winner ? bus.req_len[2*LEN_WIDTH-1:LEN_WIDTH] : bus.req_len[LEN_WIDTH-1:0];
  assign own_wdata = owner ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.wdata[DATA_WIDTH-1:0];

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    prio_d     = prio;
    addr_d     = addr;
    remain_d   = remain;
    tcnt_d     = tcnt;
    gnt_d      = 2'b00;
    err_d      = 1'b0;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    rdenlast_d = 1'b0;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    wdata_d    = wdata_q;
    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d  = winner ? 2'b10 : 2'b01;
          prio_d = ~winner;
          // A zero-length request is acknowledged and flagged but never reaches the bus.
          if (win_len == '0) begin
            err_d = 1'b1;
          end else begin
            owner_d  = winner;
            addr_d   = win_addr;
            remain_d = win_len;
            state_d  = win_wr ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        wren_d   = 1'b1;
        waddr_d  = addr;
        wdata_d  = own_wdata;
        addr_d   = addr + ADDR_WIDTH'(1);
        remain_d = remain - LEN_WIDTH'(1);
        if (remain == LEN_WIDTH'(1)) state_d = IDLE;
      end
      READ: begin
        rden_d   = 1'b1;
        raddr_d  = addr;
        addr_d   = addr + ADDR_WIDTH'(1);
        remain_d = remain - LEN_WIDTH'(1);
        if (remain == LEN_WIDTH'(1)) begin
          rdenlast_d = 1'b1;
          tcnt_d     = TW'(TIMEOUT - 1);
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.lb_rvalidlast) begin
          state_d = IDLE;
        end else if (tcnt == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      addr       <= '0;
      remain     <= '0;
      tcnt       <= '0;
      gnt_q      <= 2'b00;
      err_q      <= 1'b0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      rdenlast_q <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      prio       <= prio_d;
      addr       <= addr_d;
      remain     <= remain_d;
      tcnt       <= tcnt_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
      rdenlast_q <= rdenlast_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Read returns pass straight through, but only while a read burst owns the bus.
  assign reading         = (state == READ) || (state == DRAIN);
  assign bus.rdata_o     = bus.lb_rdata;
  assign bus.rvalid_o    = reading ? {owner & bus.lb_rvalid, ~owner & bus.lb_rvalid} : 2'b00;
  assign bus.rlast_o     = reading & bus.lb_rvalidlast;
  assign bus.wready      = (state == WRITE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy        = (state != IDLE);
  assign bus.gnt         = gnt_q;
  assign bus.err         = err_q;
  assign bus.lb_wren     = wren_q;
  assign bus.lb_rden     = rden_q;
  assign bus.lb_rdenlast = rdenlast_q;
  assign bus.lb_waddr    = waddr_q;
  assign bus.lb_raddr    = raddr_q;
  assign bus.lb_wdata    = wdata_q;
endmodule

// File: tb/tb_lb_burst_arbiter.sv
// Directed bench for lb_burst_arbiter with a fixed-latency local-bus read model.
module tb_lb_burst_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int LW  = 12;
  localparam int TO  = 64;
  localparam int LAT = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic suppress_last = 1'b0;

  logic [LAT-1:0] pv = '0;
  logic [LAT-1:0] pl = '0;
  logic [DW-1:0]  pd [LAT];

  always #5 clk = ~clk;

  lb_burst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) ifc ();

  lb_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc)
  );

  // Bus model: every read strobe returns {A5, address} LAT cycles later.
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], ifc.lb_rden};
    pl    <= {pl[LAT-2:0], ifc.lb_rdenlast & ~suppress_last};
    pd[0] <= {8'hA5, ifc.lb_raddr};
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign ifc.lb_rvalid     = pv[LAT-1];
  assign ifc.lb_rvalidlast = pl[LAT-1];
  assign ifc.lb_rdata      = pd[LAT-1];

  task automatic do_reset();
    ifc.req = '0; ifc.req_wr = '0; ifc.req_addr = '0; ifc.req_len = '0; ifc.wdata = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ifc.req[p] = 1'b1;
    ifc.req_wr[p] = wr;
    ifc.req_addr[p*AW +: AW] = a;
    ifc.req_len[p*LW +: LW] = l;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({ifc.gnt, ifc.err, ifc.busy} !== 4'b0) begin n_bad++; $display("[TB] FAIL rst_ctl got=%b exp=0000", {ifc.gnt, ifc.err, ifc.busy}); end
    n_cmp++; if ({ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast} !== 3'b0) begin n_bad++; $display("[TB] FAIL rst_strobes got=%b exp=000", {ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast}); end
    n_cmp++; if ({ifc.lb_waddr, ifc.lb_raddr, ifc.lb_wdata} !== '0) begin n_bad++; $display("[TB] FAIL rst_bus got=%h exp=0", {ifc.lb_waddr, ifc.lb_raddr, ifc.lb_wdata}); end
    n_cmp++; if ({ifc.wready, ifc.rvalid_o, ifc.rlast_o} !== 5'b0) begin n_bad++; $display("[TB] FAIL rst_comb got=%b exp=00000", {ifc.wready, ifc.rvalid_o, ifc.rlast_o}); end
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 1'b1, 24'h000010, 12'd4);
    ifc.wdata[DW-1:0] = 32'd1;
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b01) begin n_bad++; $display("[TB] FAIL wr_gnt got=%b exp=01", ifc.gnt); end
    n_cmp++; if (ifc.wready !== 2'b01) begin n_bad++; $display("[TB] FAIL wr_wready0 got=%b exp=01", ifc.wready); end
    n_cmp++; if (ifc.lb_wren !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_early_wren got=%b exp=0", ifc.lb_wren); end
    ifc.req = '0;
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] exp_wr;
      @(posedge clk); #1;
      exp_wr = (i < 4) ? 2'b01 : 2'b00;
      n_cmp++; if (ifc.lb_wren !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_wren[%0d] got=%b exp=1", i, ifc.lb_wren); end
      n_cmp++; if (ifc.lb_waddr !== AW'(32'h10 + i - 1)) begin n_bad++; $display("[TB] FAIL wr_addr[%0d] got=%h exp=%h", i, ifc.lb_waddr, AW'(32'h10 + i - 1)); end
      n_cmp++; if (ifc.lb_wdata !== DW'(i)) begin n_bad++; $display("[TB] FAIL wr_data[%0d] got=%h exp=%h", i, ifc.lb_wdata, DW'(i)); end
      n_cmp++; if (ifc.wready !== exp_wr) begin n_bad++; $display("[TB] FAIL wr_wready[%0d] got=%b exp=%b", i, ifc.wready, exp_wr); end
      n_cmp++; if (ifc.busy !== (i < 4)) begin n_bad++; $display("[TB] FAIL wr_busy[%0d] got=%b exp=%b", i, ifc.busy, (i < 4)); end
      n_cmp++; if (ifc.gnt !== 2'b00) begin n_bad++; $display("[TB] FAIL wr_gnt_extra[%0d] got=%b exp=00", i, ifc.gnt); end
      ifc.wdata[DW-1:0] = DW'(i + 1);
    end
    @(posedge clk); #1;
    n_cmp++; if (ifc.lb_wren !== 1'b0) begin n_bad++; $display("[TB] FAIL wr_wren_end got=%b exp=0", ifc.lb_wren); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(1, 1'b0, 24'h040000, 12'd3);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b10) begin n_bad++; $display("[TB] FAIL rd_gnt got=%b exp=10", ifc.gnt); end
    n_cmp++; if (ifc.wready !== 2'b00) begin n_bad++; $display("[TB] FAIL rd_wready got=%b exp=00", ifc.wready); end
    ifc.req = '0;
    for (int k = 2; k <= 10; k++) begin
      logic          e_rden, e_v;
      logic [AW-1:0] e_ra;
      logic [DW-1:0] e_rd;
      @(posedge clk); #1;
      e_rden = (k >= 2) && (k <= 4);
      e_v    = (k >= 7) && (k <= 9);
      e_ra   = AW'(32'h040000 + k - 2);
      e_rd   = {8'hA5, AW'(32'h040000 + k - 7)};
      n_cmp++; if (ifc.lb_rden !== e_rden) begin n_bad++; $display("[TB] FAIL rd_rden[%0d] got=%b exp=%b", k, ifc.lb_rden, e_rden); end
      n_cmp++; if (ifc.lb_rdenlast !== (k == 4)) begin n_bad++; $display("[TB] FAIL rd_rdenlast[%0d] got=%b exp=%b", k, ifc.lb_rdenlast, (k == 4)); end
      if (e_rden) begin
        n_cmp++; if (ifc.lb_raddr !== e_ra) begin n_bad++; $display("[TB] FAIL rd_raddr[%0d] got=%h exp=%h", k, ifc.lb_raddr, e_ra); end
      end
      n_cmp++; if (ifc.rvalid_o !== {e_v, 1'b0}) begin n_bad++; $display("[TB] FAIL rd_rvalid[%0d] got=%b exp=%b", k, ifc.rvalid_o, {e_v, 1'b0}); end
      n_cmp++; if (ifc.rlast_o !== (k == 9)) begin n_bad++; $display("[TB] FAIL rd_rlast[%0d] got=%b exp=%b", k, ifc.rlast_o, (k == 9)); end
      if (e_v) begin
        n_cmp++; if (ifc.rdata_o !== e_rd) begin n_bad++; $display("[TB] FAIL rd_rdata[%0d] got=%h exp=%h", k, ifc.rdata_o, e_rd); end
      end
      n_cmp++; if (ifc.busy !== (k < 10)) begin n_bad++; $display("[TB] FAIL rd_busy[%0d] got=%b exp=%b", k, ifc.busy, (k < 10)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b0, 24'h000100, 12'd2);
    set_req(1, 1'b0, 24'h000200, 12'd2);
    for (int g = 0; g < 4; g++) begin
      logic [1:0] e_g;
      e_g = (g % 2 == 1) ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      n_cmp++; if (ifc.gnt !== e_g) begin n_bad++; $display("[TB] FAIL rr_gnt[%0d] got=%b exp=%b", g, ifc.gnt, e_g); end
      if (g == 3) ifc.req = '0;
      for (int k = 1; k <= 8; k++) begin
        logic [1:0] e_v;
        @(posedge clk); #1;
        e_v = (k == 6 || k == 7) ? e_g : 2'b00;
        n_cmp++; if (ifc.gnt !== 2'b00) begin n_bad++; $display("[TB] FAIL rr_gnt_early[%0d.%0d] got=%b exp=00", g, k, ifc.gnt); end
        n_cmp++; if (ifc.rvalid_o !== e_v) begin n_bad++; $display("[TB] FAIL rr_rvalid[%0d.%0d] got=%b exp=%b", g, k, ifc.rvalid_o, e_v); end
      end
    end
  endtask

  task automatic test_wrap_zero_len();
    logic [AW-1:0] wrap_a [3];
    wrap_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    do_reset();
    set_req(0, 1'b1, 24'hFFFFFE, 12'd3);
    ifc.wdata[DW-1:0] = 32'd7;
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b01) begin n_bad++; $display("[TB] FAIL wrap_gnt got=%b exp=01", ifc.gnt); end
    ifc.req = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (ifc.lb_wren !== 1'b1) begin n_bad++; $display("[TB] FAIL wrap_wren[%0d] got=%b exp=1", i, ifc.lb_wren); end
      n_cmp++; if (ifc.lb_waddr !== wrap_a[i]) begin n_bad++; $display("[TB] FAIL wrap_addr[%0d] got=%h exp=%h", i, ifc.lb_waddr, wrap_a[i]); end
      n_cmp++; if (ifc.lb_wdata !== DW'(7 + i)) begin n_bad++; $display("[TB] FAIL wrap_data[%0d] got=%h exp=%h", i, ifc.lb_wdata, DW'(7 + i)); end
      ifc.wdata[DW-1:0] = DW'(8 + i);
    end
    set_req(1, 1'b0, 24'h000300, 12'd0);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b10) begin n_bad++; $display("[TB] FAIL zl_gnt got=%b exp=10", ifc.gnt); end
    n_cmp++; if (ifc.err !== 1'b1) begin n_bad++; $display("[TB] FAIL zl_err got=%b exp=1", ifc.err); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL zl_busy got=%b exp=0", ifc.busy); end
    ifc.req = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast} !== 3'b0) begin n_bad++; $display("[TB] FAIL zl_strobes[%0d] got=%b exp=000", i, {ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast}); end
      n_cmp++; if ({ifc.err, ifc.busy, ifc.gnt} !== 4'b0) begin n_bad++; $display("[TB] FAIL zl_after[%0d] got=%b exp=0000", i, {ifc.err, ifc.busy, ifc.gnt}); end
    end
    // Port 1's zero-length grant must have handed priority back to port 0.
    set_req(0, 1'b1, 24'h000010, 12'd1);
    set_req(1, 1'b1, 24'h000020, 12'd1);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b01) begin n_bad++; $display("[TB] FAIL zl_prio_gnt got=%b exp=01", ifc.gnt); end
    ifc.req = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int waited;
    do_reset();
    suppress_last = 1'b1;
    set_req(0, 1'b0, 24'h000100, 12'd2);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b01) begin n_bad++; $display("[TB] FAIL to_gnt got=%b exp=01", ifc.gnt); end
    ifc.req = '0;
    for (int k = 2; k <= TO + 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (ifc.err !== (k == TO + 3)) begin n_bad++; $display("[TB] FAIL to_err[%0d] got=%b exp=%b", k, ifc.err, (k == TO + 3)); end
      n_cmp++; if (ifc.busy !== (k < TO + 3)) begin n_bad++; $display("[TB] FAIL to_busy[%0d] got=%b exp=%b", k, ifc.busy, (k < TO + 3)); end
    end
    suppress_last = 1'b0;
    set_req(1, 1'b0, 24'h000400, 12'd1);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b10) begin n_bad++; $display("[TB] FAIL to_next_gnt got=%b exp=10", ifc.gnt); end
    ifc.req = '0;
    waited = 0;
    while (ifc.busy === 1'b1 && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL to_next_done got=%b exp=0 after %0d cycles", ifc.busy, waited); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b0, 24'h000200, 12'd8);
    @(posedge clk); #1;
    n_cmp++; if (ifc.gnt !== 2'b01) begin n_bad++; $display("[TB] FAIL rm_gnt got=%b exp=01", ifc.gnt); end
    ifc.req = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    n_cmp++; if ({ifc.gnt, ifc.err, ifc.busy, ifc.wready} !== 6'b0) begin n_bad++; $display("[TB] FAIL rm_ctl got=%b exp=000000", {ifc.gnt, ifc.err, ifc.busy, ifc.wready}); end
    n_cmp++; if ({ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast} !== 3'b0) begin n_bad++; $display("[TB] FAIL rm_strobes got=%b exp=000", {ifc.lb_wren, ifc.lb_rden, ifc.lb_rdenlast}); end
    n_cmp++; if ({ifc.lb_waddr, ifc.lb_raddr, ifc.lb_wdata} !== '0) begin n_bad++; $display("[TB] FAIL rm_bus got=%h exp=0", {ifc.lb_waddr, ifc.lb_raddr, ifc.lb_wdata}); end
    for (int k = 5; k <= 10; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({ifc.rvalid_o, ifc.rlast_o} !== 3'b0) begin n_bad++; $display("[TB] FAIL rm_late_ret[%0d] got=%b exp=000", k, {ifc.rvalid_o, ifc.rlast_o}); end
      n_cmp++; if ({ifc.busy, ifc.lb_rden} !== 2'b0) begin n_bad++; $display("[TB] FAIL rm_idle[%0d] got=%b exp=00", k, {ifc.busy, ifc.lb_rden}); end
    end
  endtask

  initial begin
    $display("[TB] lb_burst_arbiter directed tests start");
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wrap_zero_len();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lb_burst_arbiter.md
# lb_burst_arbiter

Two-port burst arbiter and sequencer in front of the local-bus BRAM controller. Port 0 is the host bridge; port 1 is the on-chip readback engine that streams acquisition, accumulation and DAC-monitor buffers. Each accepted request becomes a contiguous write or read burst with one beat per cycle. Grants alternate round-robin, and read data is routed back to the owning requester.

## Interface
Parameters:
- ADDR_WIDTH, default 24: local-bus address width.
- DATA_WIDTH, default 32: local-bus data width.
- LEN_WIDTH, default 12: width of the burst length field, in beats.
- TIMEOUT, default 64: maximum number of cycles spent in DRAIN waiting for the last read beat.

Ports:
- clk, in, 1: local-bus clock; all logic runs on this single clock.
- rstn, in, 1: synchronous, active-low reset.
- req, in, 2: request from each port. Held until that port's gnt pulse.
- req_wr, in, 2: per port, 1 = write burst, 0 = read burst.
- req_addr, in, 2*ADDR_WIDTH: start address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len, in, 2*LEN_WIDTH: burst length in beats; 0 is illegal.
- gnt, out, 2: one-cycle pulse when a request is accepted.
- wready, out, 2: combinational; the owner's wdata is consumed in each cycle this is high.
- wdata, in, 2*DATA_WIDTH: write data for each port.
- rdata_o, out, DATA_WIDTH: read data, shared by both ports.
- rvalid_o, out, 2: read-data valid for each port.
- rlast_o, out, 1: marks the final read beat.
- err, out, 1: one-cycle pulse on a len=0 request or a drain timeout.
- busy, out, 1: high whenever the state is not IDLE.
- lb_wren, lb_rden, lb_rdenlast, out, 1 each: bus strobes.
- lb_waddr, lb_raddr, out, ADDR_WIDTH: bus addresses.
- lb_wdata, out, DATA_WIDTH: bus write data.
- lb_rdata, in, DATA_WIDTH: bus read data.
- lb_rvalid, lb_rvalidlast, in, 1 each: bus read-return strobes.

## Operation
States are IDLE, WRITE, READ and DRAIN. Registers: owner (1 bit), prio (1 bit), addr counter, beats-remaining counter, timeout counter.

- **IDLE, arbitration.**
  - If only one req bit is set, that port wins.
  - If both are set, port prio wins.
  - On a winner: gnt[winner]=1 for one cycle, owner=winner, prio=~winner, counters loaded, and the state moves to WRITE or READ according to req_wr.
- **len=0 request.** gnt and err pulse together, the state stays IDLE, there is no bus activity, and prio still toggles.
- **WRITE.**
  - wready[owner]=1 in every WRITE cycle.
  - Each cycle registers lb_wren=1, lb_waddr=addr and lb_wdata=wdata[owner], then increments addr.
  - After the final beat the state returns to IDLE.
  - The requester cannot stall; its data must be valid in every wready cycle.
- **READ.**
  - Each cycle registers lb_rden=1 and lb_raddr=addr.
  - On the final beat lb_rdenlast=1 and the state moves to DRAIN.
- **Read returns (READ and DRAIN).**
  - rdata_o = lb_rdata.
  - rvalid_o[owner] = lb_rvalid; rlast_o = lb_rvalidlast.
- **DRAIN exit.**
  - lb_rvalidlast returns the state to IDLE on the next cycle.
  - If TIMEOUT cycles pass without it: err pulses and the state returns to IDLE.
- **Stray returns.** lb_rvalid/lb_rvalidlast seen in IDLE or WRITE are ignored; all rvalid_o stay 0.
- **Address arithmetic.** addr increments modulo 2^ADDR_WIDTH, so 0xFFFFFF+1 wraps to 0x000000.
- **Requests while busy.** A req arriving when the block is not IDLE waits; it is never dropped.

## Timing
- **Reset** forces every output register to 0 (gnt, lb_*, err, busy), with state=IDLE, owner=0 and prio=0. Reset mid-burst abandons the burst; returns arriving after reset are ignored.
- **Burst timing** (req sampled high in IDLE at cycle N, length L):
  - Cycle N+1: gnt pulse, first internal beat.
  - Cycles N+2 … N+L+1: bus strobes, one cycle after each beat.
- **Writes:** wready is high in cycles N+1 … N+L. The state is IDLE at N+L+1, and the next grant can occur at N+L+2.
- **Reads:**
  - lb_rdenlast is asserted at N+L+1.
  - rvalid_o is combinational from lb_rvalid, with zero added latency.
  - After lb_rvalidlast at cycle M, IDLE is reached at M+1.
- **Timeout:** err is asserted at cycle D+TIMEOUT, where D is the first cycle in DRAIN.

## Test plan
- **Single write burst.** Port 0 writes 4 beats at 0x000010 with data 1..4 → lb_wren high for 4 cycles starting at N+2, addresses 0x10–0x13, lb_wdata 1,2,3,4; gnt[0] pulses at N+1.
- **Single read burst.** Port 1 reads 3 beats at 0x040000; a bus model returns data 5 cycles later → lb_rdenlast on the 3rd beat, rvalid_o[1] high 3 cycles, rlast_o on the 3rd, rvalid_o[0] stays 0.
- **Contention.** Both ports request continuously, each with len=2 reads → grants alternate 0,1,0,1; no grant is issued before the previous rvalidlast.
- **Wrap and zero length.** Port 0 writes 3 beats at 0xFFFFFE → addresses FFFFFE, FFFFFF, 000000. A len=0 request → gnt and err pulse in the same cycle, with no strobes.
- **Timeout.** A read of 2 beats with the bus model never asserting rvalidlast → err exactly TIMEOUT cycles after entering DRAIN, then IDLE, and the next request is granted.
- **Reset mid-operation.** rstn is held low for 1 cycle during beat 3 of an 8-beat read → all outputs 0 the next cycle, state IDLE, and late lb_rvalid produces no rvalid_o.
